regfile_wb_unit: RTL and testbench
==================================

Name: regfile_wb_unit

Overview:
- Write-back side of the 32x32 register file: collects write requests from the ALU result path, the load path and the jump-and-link path.
- Orders requests through a small FIFO and drives the register file's single write port (write enable, 5-bit address, 32-bit data) with at most one write per cycle.
- Reports per-read-address pending status so decode can stall on registers that still have writes in flight.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, minimum 2.
- LINK_REG, 31, destination register for link writes.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- link_valid  input  1  link write request.
- link_data  input  32  return address to write to LINK_REG.
- link_ready  output  1  link request accepted this cycle.
- ld_valid  input  1  load write request.
- ld_addr  input  5  load destination register.
- ld_data  input  32  load data.
- ld_ready  output  1  load request accepted this cycle.
- alu_valid  input  1  ALU write request.
- alu_addr  input  5  ALU destination register.
- alu_data  input  32  ALU result.
- alu_ready  output  1  ALU request accepted this cycle.
- rf_we  output  1  register-file write enable (registered).
- rf_waddr  output  5  register-file write address (registered).
- rf_wdata  output  32  register-file write data (registered).
- rd_addr_1  input  5  decode read address 1.
- rd_addr_2  input  5  decode read address 2.
- pend_1  output  1  write to rd_addr_1 still in flight.
- pend_2  output  1  write to rd_addr_2 still in flight.
- count  output  log2(DEPTH)+1  FIFO occupancy.
- empty  output  1  FIFO empty and rf_we low.

Behaviour:
- Reset (rst=0, asynchronous):
  - FIFO pointers and count cleared.
  - rf_we=0, rf_waddr=0, rf_wdata=0.
  - pend_1=0, pend_2=0, empty=1.
  - Reset applied mid-operation discards every queued entry. No write is issued after reset releases until a new request arrives.
- Arbitration (combinational), fixed priority link > load > ALU:
  - space = (count < DEPTH), evaluated before this cycle's pop.
  - link_ready = link_valid & space.
  - ld_ready = ld_valid & space & ~link_valid.
  - alu_ready = alu_valid & space & ~link_valid & ~ld_valid.
  - At most one request is accepted per cycle. A requester that is not accepted holds valid and its payload until its ready is high.
- Register $0: an accepted request whose destination is 0 is acknowledged (ready high) but not enqueued, so count is unchanged.
- Enqueue: on the accepting rising edge, the entry {addr, data} is written at the tail. The link entry address is LINK_REG.
- Dequeue, every rising edge:
  - If the FIFO is non-empty at the edge, the head is popped into rf_waddr/rf_wdata and rf_we=1 for exactly that cycle.
  - Otherwise rf_we=0; rf_waddr and rf_wdata hold their previous values.
  - The register file samples the write on the falling edge inside that cycle.
- Latency: a request accepted at edge N into an empty FIFO appears with rf_we=1 after edge N+1. There is no bypass from input directly to the output registers.
- Simultaneous push and pop at the same edge:
  - Allowed; count is unchanged.
  - When full, space=0 even if a pop occurs that edge, so no push is accepted.
- Ordering: entries drain strictly in acceptance order. Multiple writes to the same register land in that order, so the last accepted value wins.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- Pending lookup (combinational):
  - pend_x = (rd_addr_x != 0) and rd_addr_x matches the address of any valid FIFO entry, or of the output stage while rf_we=1.
  - rd_addr_x = 0 always gives pend_x=0.
- empty = (count == 0) & ~rf_we.

Test Plan:
1. Reset then idle: rst low for 2 cycles, release, no requests. Required: rf_we=0, count=0, empty=1, all readies 0.
2. Single ALU write: alu_valid=1, alu_addr=5, alu_data=0x1234 for one cycle, accepted at edge N. Required: rf_we=1, rf_waddr=5, rf_wdata=0x1234 after edge N+1 only. pend_1=1 for rd_addr_1=5 from edge N until rf_we drops.
3. Three-way collision: link_data=0x400, ld_addr=8, ld_data=0xAA, alu_addr=9, alu_data=0xBB all valid in one cycle, with requesters holding valid until accepted. Required:
   - Accept order is link, load, ALU over three consecutive edges.
   - Writes in that order: (31,0x400), (8,0xAA), (9,0xBB).
4. Back-pressure with DEPTH=4: ALU writes to regs 1..6 presented back-to-back, valid held until accepted. Required:
   - Each register is written exactly once with its value.
   - No ALU request is accepted while count=4, including in a cycle where a pop occurs.
5. $0 filtering: ld_addr=0, ld_data=0xFFFF. Required: ld_ready=1, count stays 0, no rf_we pulse, pend_1=0 for rd_addr_1=0.
6. Reset mid-drain: enqueue 3 writes, assert rst after the first write issues. Required: rf_we=0 immediately, count=0, and no further writes after release.

Source files
------------

// File: rtl/regfile_wb_unit.sv
// Write-back unit for the 32x32 register file: arbitrates link/load/ALU write requests
// into an in-order FIFO that drives the single register-file write port.
module regfile_wb_unit #(
    parameter int         DEPTH    = 4,
    parameter logic [4:0] LINK_REG = 5'd31
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     link_valid,
    input  logic [31:0]              link_data,
    output logic                     link_ready,
    input  logic                     ld_valid,
    input  logic [4:0]               ld_addr,
    input  logic [31:0]              ld_data,
    output logic                     ld_ready,
    input  logic                     alu_valid,
    input  logic [4:0]               alu_addr,
    input  logic [31:0]              alu_data,
    output logic                     alu_ready,
    output logic                     rf_we,
    output logic [4:0]               rf_waddr,
    output logic [31:0]              rf_wdata,
    input  logic [4:0]               rd_addr_1,
    input  logic [4:0]               rd_addr_2,
    output logic                     pend_1,
    output logic                     pend_2,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [4:0]    r_fifoAddr [DEPTH];
    logic [31:0]   r_fifoData [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    logic          w_space;
    logic          w_accept;
    logic          w_push;
    logic          w_pop;
    logic [4:0]    w_accAddr;
    logic [31:0]   w_accData;
    logic [AW-1:0] w_off [DEPTH];
    logic [DEPTH-1:0] w_entryValid;

    // Fixed priority link > load > ALU; space is judged before this edge's pop.
    always_comb begin
        w_space    = (r_count < CW'(DEPTH));
        link_ready = link_valid & w_space;
        ld_ready   = ld_valid & w_space & ~link_valid;
        alu_ready  = alu_valid & w_space & ~link_valid & ~ld_valid;
        w_accAddr  = 5'd0;
        w_accData  = 32'd0;
        if (link_ready) begin
            w_accAddr = LINK_REG;
            w_accData = link_data;
        end else if (ld_ready) begin
            w_accAddr = ld_addr;
            w_accData = ld_data;
        end else if (alu_ready) begin
            w_accAddr = alu_addr;
            w_accData = alu_data;
        end
        w_accept = link_ready | ld_ready | alu_ready;
        w_push   = w_accept & (w_accAddr != 5'd0);
        w_pop    = (r_count != '0);
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifoAddr[r_wptr] <= w_accAddr;
            r_fifoData[r_wptr] <= w_accData;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            rf_we    <= 1'b0;
            rf_waddr <= 5'd0;
            rf_wdata <= 32'd0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            rf_we   <= w_pop;
            if (w_pop) begin
                rf_waddr <= r_fifoAddr[r_rptr];
                rf_wdata <= r_fifoData[r_rptr];
            end
        end
    end

    // An entry is live when its distance from the read pointer is below the occupancy.
    for (genvar g = 0; g < DEPTH; g++) begin : g_valid
        localparam logic [AW-1:0] IDX = AW'(g);
        assign w_off[g]        = IDX - r_rptr;
        assign w_entryValid[g] = ({1'b0, w_off[g]} < r_count);
    end

    always_comb begin
        pend_1 = rf_we & (rf_waddr == rd_addr_1);
        pend_2 = rf_we & (rf_waddr == rd_addr_2);
        for (int i = 0; i < DEPTH; i++) begin
            if (w_entryValid[i] && (r_fifoAddr[i] == rd_addr_1))
                pend_1 = 1'b1;
            if (w_entryValid[i] && (r_fifoAddr[i] == rd_addr_2))
                pend_2 = 1'b1;
        end
        if (rd_addr_1 == 5'd0)
            pend_1 = 1'b0;
        if (rd_addr_2 == 5'd0)
            pend_2 = 1'b0;
    end

    assign count = r_count;
    assign empty = (r_count == '0) & ~rf_we;

endmodule

// File: tb/tb_regfile_wb_unit.sv
// Bench for regfile_wb_unit: directed scenarios followed by random traffic, all
// checked cycle by cycle against a queue-based model of the write-back path.
module tb_regfile_wb_unit;

    localparam int         DEPTH    = 4;
    localparam logic [4:0] LINK_REG = 5'd31;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        link_valid = 1'b0, ld_valid = 1'b0, alu_valid = 1'b0;
    logic [31:0] link_data = '0, ld_data = '0, alu_data = '0;
    logic [4:0]  ld_addr = '0, alu_addr = '0, rd_addr_1 = '0, rd_addr_2 = '0;
    logic        link_ready, ld_ready, alu_ready, rf_we, pend_1, pend_2, empty;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [2:0]  count;

    regfile_wb_unit #(.DEPTH(DEPTH), .LINK_REG(LINK_REG)) dut (
        .clk(clk), .rst(rst),
        .link_valid(link_valid), .link_data(link_data), .link_ready(link_ready),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
        .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2),
        .pend_1(pend_1), .pend_2(pend_2), .count(count), .empty(empty)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model: queue of in-flight {addr,data} plus the visible write-port values.
    logic [36:0] modelQ[$];
    logic        expWe = 1'b0;
    logic [4:0]  expWaddr = '0;
    logic [31:0] expWdata = '0;

    // Requester state; a requester keeps its payload until the model says it was accepted.
    logic        linkV = 1'b0, ldV = 1'b0, aluV = 1'b0;
    logic [31:0] linkD = '0, ldD = '0, aluD = '0;
    logic [4:0]  ldA = '0, aluA = '0, rdA1 = '0, rdA2 = '0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic modelPend(input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
        if (expWe && expWaddr == a) return 1'b1;
        foreach (modelQ[i])
            if (modelQ[i][36:32] == a) return 1'b1;
        return 1'b0;
    endfunction

    // One clock cycle: drive, check combinational outputs, advance model, check write port.
    task automatic applyStimulus();
        logic space, expLinkR, expLdR, expAluR;
        logic [36:0] head;
        link_valid = linkV; link_data = linkD;
        ld_valid = ldV; ld_addr = ldA; ld_data = ldD;
        alu_valid = aluV; alu_addr = aluA; alu_data = aluD;
        rd_addr_1 = rdA1; rd_addr_2 = rdA2;
        #1;
        space    = (modelQ.size() < DEPTH);
        expLinkR = linkV && space;
        expLdR   = ldV && space && !linkV;
        expAluR  = aluV && space && !linkV && !ldV;
        checkOutput("link_ready", 32'(link_ready), 32'(expLinkR));
        checkOutput("ld_ready", 32'(ld_ready), 32'(expLdR));
        checkOutput("alu_ready", 32'(alu_ready), 32'(expAluR));
        checkOutput("count", 32'(count), 32'(modelQ.size()));
        checkOutput("empty", 32'(empty), 32'(modelQ.size() == 0 && !expWe));
        checkOutput("pend_1", 32'(pend_1), 32'(modelPend(rdA1)));
        checkOutput("pend_2", 32'(pend_2), 32'(modelPend(rdA2)));
        if (modelQ.size() > 0) begin
            head     = modelQ.pop_front();
            expWe    = 1'b1;
            expWaddr = head[36:32];
            expWdata = head[31:0];
        end else begin
            expWe = 1'b0;
        end
        if (expLinkR) begin
            modelQ.push_back({LINK_REG, linkD});
            linkV = 1'b0;
        end else if (expLdR) begin
            if (ldA != 5'd0) modelQ.push_back({ldA, ldD});
            ldV = 1'b0;
        end else if (expAluR) begin
            if (aluA != 5'd0) modelQ.push_back({aluA, aluD});
            aluV = 1'b0;
        end
        @(posedge clk);
        #1;
        checkOutput("rf_we", 32'(rf_we), 32'(expWe));
        checkOutput("rf_waddr", 32'(rf_waddr), 32'(expWaddr));
        checkOutput("rf_wdata", rf_wdata, expWdata);
    endtask

    task automatic modelReset();
        modelQ.delete();
        expWe = 1'b0; expWaddr = '0; expWdata = '0;
        linkV = 1'b0; ldV = 1'b0; aluV = 1'b0;
    endtask

    initial begin
        // Reset then idle.
        #2 rst = 1'b0;
        modelReset();
        @(posedge clk); @(posedge clk); #1;
        checkOutput("reset_rf_we", 32'(rf_we), 32'd0);
        checkOutput("reset_count", 32'(count), 32'd0);
        checkOutput("reset_empty", 32'(empty), 32'd1);
        rst = 1'b1;
        repeat (3) applyStimulus();

        // Single ALU write with pending tracked on read port 1.
        $display("[TB] single ALU write");
        aluV = 1'b1; aluA = 5'd5; aluD = 32'h1234; rdA1 = 5'd5; rdA2 = 5'd6;
        repeat (4) applyStimulus();

        // Three-way collision, requesters holding until accepted.
        $display("[TB] three-way collision");
        linkV = 1'b1; linkD = 32'h400;
        ldV = 1'b1; ldA = 5'd8; ldD = 32'hAA;
        aluV = 1'b1; aluA = 5'd9; aluD = 32'hBB;
        rdA1 = 5'd31; rdA2 = 5'd9;
        repeat (6) applyStimulus();

        // Back-to-back ALU writes to regs 1..6.
        $display("[TB] back-to-back ALU writes");
        for (int r = 1; r <= 6; r++) begin
            aluV = 1'b1; aluA = 5'(r); aluD = 32'h100 + 32'(r); rdA1 = 5'(r);
            for (int t = 0; t < 20 && aluV; t++) applyStimulus();
            checkOutput("alu_accept_timeout", 32'(aluV), 32'd0);
        end
        repeat (3) applyStimulus();

        // Register $0 writes are acknowledged but dropped.
        $display("[TB] zero-register filtering");
        ldV = 1'b1; ldA = 5'd0; ldD = 32'hFFFF; rdA1 = 5'd0; rdA2 = 5'd0;
        repeat (3) applyStimulus();

        // Reset during drain.
        $display("[TB] reset mid-drain");
        for (int r = 10; r < 13; r++) begin
            aluV = 1'b1; aluA = 5'(r); aluD = 32'hC000 + 32'(r); rdA1 = 5'd12;
            applyStimulus();
        end
        #2 rst = 1'b0;
        #1;
        modelReset();
        checkOutput("midreset_rf_we", 32'(rf_we), 32'd0);
        checkOutput("midreset_count", 32'(count), 32'd0);
        checkOutput("midreset_empty", 32'(empty), 32'd1);
        checkOutput("midreset_pend_1", 32'(pend_1), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        repeat (4) applyStimulus();

        // Random traffic.
        $display("[TB] random traffic");
        for (int c = 0; c < 400; c++) begin
            if (!linkV && $urandom_range(0, 3) == 0) begin
                linkV = 1'b1; linkD = $urandom();
            end
            if (!ldV && $urandom_range(0, 1) == 1) begin
                ldV = 1'b1; ldA = 5'($urandom_range(0, 31)); ldD = $urandom();
            end
            if (!aluV && $urandom_range(0, 1) == 1) begin
                aluV = 1'b1; aluA = 5'($urandom_range(0, 31)); aluD = $urandom();
            end
            rdA1 = ($urandom_range(0, 1) == 1) ? aluA : 5'($urandom_range(0, 31));
            rdA2 = ($urandom_range(0, 1) == 1) ? ldA : 5'($urandom_range(0, 31));
            applyStimulus();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
